// File: rtl/esc_sequencer_if.sv
// Flight-control <-> ESC sequencer bundle: arm/kill/command inputs and the four
// speed outputs with their write strobe and status flags.
interface esc_sequencer_if;
  logic        arm_req;
  logic        kill;
  logic        cmd_vld;
  logic [10:0] frnt_cmd;
  logic [10:0] bck_cmd;
  logic [10:0] lft_cmd;
  logic [10:0] rght_cmd;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        wrt;
  logic        motors_off;
  logic        armed;

  modport master (
    output arm_req, kill, cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, wrt, motors_off, armed
  );

  modport slave (
    input  arm_req, kill, cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    output frnt_spd, bck_spd, lft_spd, rght_spd, wrt, motors_off, armed
  );
endinterface

// File: rtl/esc_sequencer.sv
// ESC refresh timing plus OFF/ARM/RUN/RAMP flow with kill path for four motor channels.
// Optional ESC_SLEW_LIMIT_EN: limits each channel to MAX_STEP change per refresh.
module esc_sequencer #(
  parameter int unsigned UPD_PERIOD  = 1_000_000,
  parameter int unsigned ARM_UPDATES = 50,
  parameter logic [10:0] MAX_STEP    = 11'd32
) (
  input  logic            clk,
  input  logic            rst_n,
  esc_sequencer_if.slave  esc_bus
);

  localparam int CNT_W = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam int ARM_W = $clog2(ARM_UPDATES + 1);

`ifdef ESC_SLEW_LIMIT_EN
  localparam logic [10:0] STEP_LIM = MAX_STEP;
`else
  // Full-scale ceiling: every update lands directly on the target.
  localparam logic [10:0] STEP_LIM = MAX_STEP | 11'h7FF;
`endif

  typedef enum logic [1:0] {S_OFF, S_ARM, S_RUN, S_RAMP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ARM_W-1:0]  r_arm_cnt;
  logic              r_wrt;
  logic              w_tick;
  logic              w_all_zero;
  logic [10:0]       w_cmd [4];
  logic [10:0]       w_spd [4];

  function automatic logic [10:0] f_slew(input logic [10:0] cur, input logic [10:0] tgt);
    logic [10:0] diff;
    diff   = '0;
    f_slew = cur;
    if (tgt > cur) begin
      diff   = tgt - cur;
      f_slew = cur + ((diff > STEP_LIM) ? STEP_LIM : diff);
    end else if (tgt < cur) begin
      diff   = cur - tgt;
      f_slew = cur - ((diff > STEP_LIM) ? STEP_LIM : diff);
    end
  endfunction

  assign w_cmd[0] = esc_bus.frnt_cmd;
  assign w_cmd[1] = esc_bus.bck_cmd;
  assign w_cmd[2] = esc_bus.lft_cmd;
  assign w_cmd[3] = esc_bus.rght_cmd;

  assign w_tick     = (r_cnt == CNT_W'(UPD_PERIOD - 1));
  assign w_all_zero = (w_spd[0] == 11'd0) && (w_spd[1] == 11'd0) &&
                      (w_spd[2] == 11'd0) && (w_spd[3] == 11'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_wrt <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_wrt <= w_tick;
    end
  end

  // Arm counter only runs in ARM; any other state leaves it cleared for the next arm phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
    end else if (r_state != S_ARM) begin
      r_arm_cnt <= '0;
    end else if (w_tick) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OFF;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (esc_bus.kill) begin
      w_state_next = S_OFF;
    end else begin
      unique case (r_state)
        S_OFF:  if (esc_bus.arm_req) w_state_next = S_ARM;
        S_ARM: begin
          if (!esc_bus.arm_req)
            w_state_next = S_OFF;
          else if (w_tick && (r_arm_cnt == ARM_W'(ARM_UPDATES - 1)))
            w_state_next = S_RUN;
        end
        S_RUN:  if (!esc_bus.arm_req) w_state_next = S_RAMP;
        S_RAMP: begin
          if (esc_bus.arm_req) w_state_next = S_RUN;
          else if (w_all_zero) w_state_next = S_OFF;
        end
        default: w_state_next = S_OFF;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [10:0] r_tgt;
      logic [10:0] r_spd;
      logic [10:0] w_run_nxt;
      logic [10:0] w_ramp_nxt;

      assign w_run_nxt  = f_slew(r_spd, r_tgt);
      assign w_ramp_nxt = f_slew(r_spd, 11'd0);

      // Speeds move only on the refresh edge, except kill which zeroes immediately.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tgt <= '0;
          r_spd <= '0;
        end else begin
          if (esc_bus.cmd_vld) r_tgt <= w_cmd[gi];
          if (esc_bus.kill) begin
            r_spd <= '0;
          end else if (w_tick) begin
            unique case (r_state)
              S_RUN:   r_spd <= w_run_nxt;
              S_RAMP:  r_spd <= w_ramp_nxt;
              default: r_spd <= '0;
            endcase
          end
        end
      end

      assign w_spd[gi] = r_spd;
    end
  endgenerate

  assign esc_bus.frnt_spd   = w_spd[0];
  assign esc_bus.bck_spd    = w_spd[1];
  assign esc_bus.lft_spd    = w_spd[2];
  assign esc_bus.rght_spd   = w_spd[3];
  assign esc_bus.wrt        = r_wrt;
  assign esc_bus.motors_off = (r_state == S_OFF);
  assign esc_bus.armed      = (r_state == S_RUN);

endmodule

// File: tb/tb_esc_sequencer.sv
// Directed bench for esc_sequencer: table of per-refresh expectations plus
// hand sequences for kill, command-on-tick and asynchronous reset.
module tb_esc_sequencer;

`ifdef ESC_SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  esc_sequencer_if bus ();

  esc_sequencer #(
    .UPD_PERIOD (16),
    .ARM_UPDATES(3),
    .MAX_STEP   (11'd32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .esc_bus(bus)
  );

  typedef struct {
    bit arm;
    bit cmd;
    int f_cmd;
    int b_cmd;
    int e_frnt;
    int e_bck;
    bit e_armed;
    bit e_moff;
    bit e_moff_nxt;
  } vec_t;

  vec_t vecs [31];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(bit arm, bit cmd, int fc, int bc, int ef, int eb,
                              bit ea, bit em, bit emn);
    vec_t v;
    v.arm = arm; v.cmd = cmd; v.f_cmd = fc; v.b_cmd = bc;
    v.e_frnt = ef; v.e_bck = eb; v.e_armed = ea; v.e_moff = em; v.e_moff_nxt = emn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_wrt(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wrt && n < 40);
    n_checks++;
    if (!bus.wrt) begin
      n_fail++;
      $display("FAIL %s: got no wrt within %0d cycles, expected wrt", name, n);
    end
  endtask

  task automatic run_vec(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    bus.arm_req = vecs[i].arm;
    if (vecs[i].cmd) begin
      bus.frnt_cmd = 11'(vecs[i].f_cmd);
      bus.bck_cmd  = 11'(vecs[i].b_cmd);
      bus.cmd_vld  = 1'b1;
      @(negedge clk);
      bus.cmd_vld  = 1'b0;
    end
    wait_wrt({nm, "_wrt"});
    check({nm, "_frnt"},  32'(bus.frnt_spd),   32'(vecs[i].e_frnt));
    check({nm, "_bck"},   32'(bus.bck_spd),    32'(vecs[i].e_bck));
    check({nm, "_lft"},   32'(bus.lft_spd),    32'd0);
    check({nm, "_armed"}, 32'(bus.armed),      32'(vecs[i].e_armed));
    check({nm, "_moff"},  32'(bus.motors_off), 32'(vecs[i].e_moff));
    @(negedge clk);
    check({nm, "_wrt_low"},  32'(bus.wrt),        32'd0);
    check({nm, "_moff_nxt"}, 32'(bus.motors_off), 32'(vecs[i].e_moff_nxt));
    $display("vec %0d: arm=%0d frnt=%0d bck=%0d armed=%0d motors_off=%0d",
             i, vecs[i].arm, vecs[i].e_frnt, vecs[i].e_bck, vecs[i].e_armed, vecs[i].e_moff);
  endtask

  initial begin
    int n;
    // Arming from idle, ramp-up, retarget down, retarget up, disarm ramp.
    vecs[0]  = mk(0, 0,   0,  0,   0,   0, 0, 1, 1);
    vecs[1]  = mk(1, 1, 100, 50,   0,   0, 0, 0, 0);
    vecs[2]  = mk(1, 0,   0,  0,   0,   0, 0, 0, 0);
    vecs[3]  = mk(1, 0,   0,  0,   0,   0, 1, 0, 0);
    vecs[4]  = mk(1, 0,   0,  0, SLEW ?  32 : 100, SLEW ? 32 : 50, 1, 0, 0);
    vecs[5]  = mk(1, 0,   0,  0, SLEW ?  64 : 100, 50, 1, 0, 0);
    vecs[6]  = mk(1, 0,   0,  0, SLEW ?  96 : 100, 50, 1, 0, 0);
    vecs[7]  = mk(1, 0,   0,  0, 100, 50, 1, 0, 0);
    vecs[8]  = mk(1, 1,  10, 50, SLEW ?  68 : 10, 50, 1, 0, 0);
    vecs[9]  = mk(1, 0,   0,  0, SLEW ?  36 : 10, 50, 1, 0, 0);
    vecs[10] = mk(1, 0,   0,  0,  10, 50, 1, 0, 0);
    vecs[11] = mk(1, 0,   0,  0,  10, 50, 1, 0, 0);
    vecs[12] = mk(1, 1, 100, 50, SLEW ?  42 : 100, 50, 1, 0, 0);
    vecs[13] = mk(1, 0,   0,  0, SLEW ?  74 : 100, 50, 1, 0, 0);
    vecs[14] = mk(1, 0,   0,  0, 100, 50, 1, 0, 0);
    vecs[15] = mk(0, 0,   0,  0, SLEW ?  68 : 0, SLEW ? 18 : 0, 0, 0, !SLEW);
    vecs[16] = mk(0, 0,   0,  0, SLEW ?  36 : 0, 0, 0, !SLEW, !SLEW);
    vecs[17] = mk(0, 0,   0,  0, SLEW ?   4 : 0, 0, 0, !SLEW, !SLEW);
    vecs[18] = mk(0, 0,   0,  0,   0,  0, 0, !SLEW, 1);
    vecs[19] = mk(0, 0,   0,  0,   0,  0, 0, 1, 1);
    vecs[20] = mk(1, 0,   0,  0,   0,  0, 0, 0, 0);
    vecs[21] = mk(1, 0,   0,  0,   0,  0, 0, 0, 0);
    vecs[22] = mk(1, 0,   0,  0,   0,  0, 1, 0, 0);
    vecs[23] = mk(1, 0,   0,  0, SLEW ?  32 : 100, SLEW ? 32 : 50, 1, 0, 0);
    // Re-arm after kill release.
    vecs[24] = mk(1, 0,   0,  0,   0,  0, 0, 0, 0);
    vecs[25] = mk(1, 0,   0,  0,   0,  0, 0, 0, 0);
    vecs[26] = mk(1, 0,   0,  0,   0,  0, 1, 0, 0);
    vecs[27] = mk(1, 0,   0,  0, SLEW ?  32 : 100, SLEW ? 32 : 50, 1, 0, 0);
    vecs[28] = mk(1, 0,   0,  0, SLEW ?  64 : 100, 50, 1, 0, 0);
    vecs[29] = mk(1, 0,   0,  0, SLEW ?  96 : 100, 50, 1, 0, 0);
    vecs[30] = mk(1, 0,   0,  0, 100, 50, 1, 0, 0);

    bus.arm_req = 1'b0; bus.kill = 1'b0; bus.cmd_vld = 1'b0;
    bus.frnt_cmd = '0; bus.bck_cmd = '0; bus.lft_cmd = '0; bus.rght_cmd = '0;

    repeat (3) @(negedge clk);
    check("rst_frnt",  32'(bus.frnt_spd),   32'd0);
    check("rst_rght",  32'(bus.rght_spd),   32'd0);
    check("rst_wrt",   32'(bus.wrt),        32'd0);
    check("rst_moff",  32'(bus.motors_off), 32'd1);
    check("rst_armed", 32'(bus.armed),      32'd0);
    $display("reset: motors_off=%0d armed=%0d", bus.motors_off, bus.armed);
    rst_n = 1'b1;

    // Idle refresh cadence: one-cycle wrt every 16 cycles in OFF.
    wait_wrt("idle_wrt");
    @(negedge clk);
    check("idle_wrt_width", 32'(bus.wrt), 32'd0);
    n = 1;
    while (!bus.wrt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_wrt_period", 32'(n), 32'd16);
    check("idle_moff", 32'(bus.motors_off), 32'd1);
    $display("idle: wrt period=%0d", n);

    for (int i = 0; i <= 23; i++) run_vec(i);

    // Kill in RUN: zeroes at the next edge and holds OFF while asserted.
    bus.kill = 1'b1;
    @(negedge clk);
    check("kill_frnt",  32'(bus.frnt_spd),   32'd0);
    check("kill_bck",   32'(bus.bck_spd),    32'd0);
    check("kill_moff",  32'(bus.motors_off), 32'd1);
    check("kill_armed", 32'(bus.armed),      32'd0);
    $display("kill: frnt=%0d motors_off=%0d", bus.frnt_spd, bus.motors_off);
    for (int k = 0; k < 2; k++) begin
      wait_wrt("kill_hold_wrt");
      check("kill_hold_moff", 32'(bus.motors_off), 32'd1);
      check("kill_hold_frnt", 32'(bus.frnt_spd),   32'd0);
      $display("kill hold %0d: motors_off=%0d", k, bus.motors_off);
    end
    @(negedge clk);
    bus.kill = 1'b0;

    for (int i = 24; i <= 30; i++) run_vec(i);

    // Command strobe on the tick cycle lands one refresh later.
    repeat (14) @(negedge clk);
    bus.frnt_cmd = 11'd200;
    bus.bck_cmd  = 11'd50;
    bus.lft_cmd  = 11'd40;
    bus.cmd_vld  = 1'b1;
    @(negedge clk);
    bus.cmd_vld  = 1'b0;
    check("tick_cmd_wrt",  32'(bus.wrt),      32'd1);
    check("tick_cmd_frnt", 32'(bus.frnt_spd), 32'd100);
    check("tick_cmd_lft",  32'(bus.lft_spd),  32'd0);
    $display("tick cmd: frnt=%0d lft=%0d", bus.frnt_spd, bus.lft_spd);
    wait_wrt("tick_next_wrt");
    check("tick_next_frnt", 32'(bus.frnt_spd), SLEW ? 32'd132 : 32'd200);
    check("tick_next_lft",  32'(bus.lft_spd),  SLEW ? 32'd32  : 32'd40);
    $display("tick next: frnt=%0d lft=%0d", bus.frnt_spd, bus.lft_spd);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_frnt",  32'(bus.frnt_spd),   32'd0);
    check("arst_lft",   32'(bus.lft_spd),    32'd0);
    check("arst_moff",  32'(bus.motors_off), 32'd1);
    check("arst_armed", 32'(bus.armed),      32'd0);
    $display("async reset: frnt=%0d motors_off=%0d", bus.frnt_spd, bus.motors_off);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
